// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and enable constants
package uart_pkg;

  localparam int STATE_W = 5;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [STATE_W-1:0] {
    INTERVAL  = 5'b00001,
    STARTBIT  = 5'b00010,
    DATABITS  = 5'b00100,
    PARITYBIT = 5'b01000,
    STOPBIT   = 5'b10000
  } state_e;

endpackage

// File: rtl/tmr_vote.sv
// rtl/tmr_vote.sv - bitwise 2-of-3 majority voter
module tmr_vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/fsm_tx.sv
// rtl/fsm_tx.sv - UART transmit controller with one-entry holding register
// and triplicated, majority-voted state and bit counter
module fsm_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter bit TMR_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p_Enable_i,
  input  logic                 BaudSig_i,
  input  logic                 p_ParityEnable_i,
  input  logic                 p_ParityOdd_i,
  input  logic                 p_TwoStop_i,
  input  logic [DATA_BITS-1:0] Data_i,
  input  logic                 DataValid_i,
  output logic                 DataReady_o,
  output logic                 Tx_o,
  output logic [STATE_W-1:0]   State_o,
  output logic [3:0]           BitCounter_o,
  output logic                 Busy_o,
  output logic                 ByteDone_o
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic [STATE_W-1:0]   st_a, st_b, st_c, st_vote;
  logic [3:0]           cnt_a, cnt_b, cnt_c, cnt_vote;
  state_e               st_v, st_d;
  logic [3:0]           cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, hold_data;
  logic                 hold_valid, capture, load;
  logic                 parity_q, parity_d;
  logic                 two_stop_q, two_stop_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  assign DataReady_o = !hold_valid && p_Enable_i;
  assign capture     = DataValid_i && DataReady_o;

  // capture needs an empty register and load needs a full one, so they never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= DISABLE;
      hold_data  <= '0;
    end else if (load) begin
      hold_valid <= DISABLE;
    end else if (capture) begin
      hold_valid <= ENABLE;
      hold_data  <= Data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_a       <= INTERVAL;
      cnt_a      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= DISABLE;
    end else begin
      st_a       <= st_d;
      cnt_a      <= cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      two_stop_q <= two_stop_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  generate
    if (TMR_EN) begin : g_tmr
      // every copy is rewritten from the voted next state, scrubbing a single upset
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          st_b  <= INTERVAL;
          st_c  <= INTERVAL;
          cnt_b <= '0;
          cnt_c <= '0;
        end else begin
          st_b  <= st_d;
          st_c  <= st_d;
          cnt_b <= cnt_d;
          cnt_c <= cnt_d;
        end
      end

      tmr_vote #(.W(STATE_W)) u_vote_st (.a(st_a), .b(st_b), .c(st_c), .y(st_vote));
      tmr_vote #(.W(4)) u_vote_cnt (.a(cnt_a), .b(cnt_b), .c(cnt_c), .y(cnt_vote));
    end else begin : g_single
      assign st_b     = st_a;
      assign st_c     = st_a;
      assign cnt_b    = cnt_a;
      assign cnt_c    = cnt_a;
      assign st_vote  = st_a;
      assign cnt_vote = cnt_a;
    end
  endgenerate

  assign st_v = state_e'(st_vote);

  // tx_d is the bit that will be on the line in the state being entered
  always_comb begin
    st_d       = st_v;
    cnt_d      = cnt_vote;
    shift_d    = shift_q;
    parity_d   = parity_q;
    two_stop_d = two_stop_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = DISABLE;
    load       = 1'b0;

    case (st_v)
      INTERVAL: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (BaudSig_i && hold_valid && p_Enable_i) load = 1'b1;
      end
      STARTBIT: begin
        if (BaudSig_i) begin
          st_d  = DATABITS;
          cnt_d = '0;
          tx_d  = shift_q[0];
        end
      end
      DATABITS: begin
        if (BaudSig_i) begin
          shift_d = shift_q >> 1;
          if (cnt_vote == LAST_BIT) begin
            cnt_d = '0;
            if (p_ParityEnable_i) begin
              st_d = PARITYBIT;
              tx_d = parity_q;
            end else begin
              st_d       = STOPBIT;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_vote + 4'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      PARITYBIT: begin
        if (BaudSig_i) begin
          st_d       = STOPBIT;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      STOPBIT: begin
        if (BaudSig_i) begin
          if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d = ENABLE;
            if (hold_valid && p_Enable_i) begin
              load = 1'b1;
            end else begin
              st_d = INTERVAL;
              tx_d = 1'b1;
            end
          end
        end
      end
      default: begin
        st_d  = INTERVAL;
        cnt_d = '0;
        tx_d  = 1'b1;
      end
    endcase

    // parity and stop mode are frozen here so the frame in flight ignores later input changes
    if (load) begin
      st_d       = STARTBIT;
      cnt_d      = '0;
      shift_d    = hold_data;
      parity_d   = (^hold_data) ^ p_ParityOdd_i;
      two_stop_d = p_TwoStop_i;
      stop_cnt_d = 1'b0;
      tx_d       = 1'b0;
    end
  end

  assign Tx_o         = tx_q;
  assign State_o      = st_vote;
  assign BitCounter_o = cnt_vote;
  assign Busy_o       = (st_vote != INTERVAL);
  assign ByteDone_o   = done_q;

endmodule

// File: tb/tb_fsm_tx.sv
// tb/tb_fsm_tx.sv - scoreboard bench decoding Tx_o frames against queued expectations
module tb_fsm_tx;
  import uart_pkg::*;

  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p_Enable_i = 1'b1;
  logic          BaudSig_i = 1'b0;
  logic          p_ParityEnable_i = 1'b0;
  logic          p_ParityOdd_i = 1'b0;
  logic          p_TwoStop_i = 1'b0;
  logic [DB-1:0] Data_i = '0;
  logic          DataValid_i = 1'b0;
  logic          DataReady_o, Tx_o, Busy_o, ByteDone_o;
  logic [4:0]    State_o;
  logic [3:0]    BitCounter_o;

  fsm_tx #(.DATA_BITS(DB), .TMR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .p_Enable_i(p_Enable_i), .BaudSig_i(BaudSig_i),
    .p_ParityEnable_i(p_ParityEnable_i), .p_ParityOdd_i(p_ParityOdd_i),
    .p_TwoStop_i(p_TwoStop_i), .Data_i(Data_i), .DataValid_i(DataValid_i),
    .DataReady_o(DataReady_o), .Tx_o(Tx_o), .State_o(State_o),
    .BitCounter_o(BitCounter_o), .Busy_o(Busy_o), .ByteDone_o(ByteDone_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_bit;
    logic       two_stop;
  } frame_t;

  frame_t exp_q[$];
  int     errors = 0;
  int     checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one-cycle tick every 16 clocks
  initial begin
    int bcnt = 0;
    forever begin
      @(negedge clk);
      bcnt = (bcnt == 15) ? 0 : bcnt + 1;
      BaudSig_i = (bcnt == 15);
    end
  end

  // line decoder: each tick edge presents the next bit of the frame
  int         ph = 0;
  int         bit_idx = 0;
  int         stops_left = 0;
  int         gap = 0;
  int         last_gap = -1;
  int         frames_done = 0;
  logic       done_expect = 1'b0;
  logic       last_tx = 1'b1;
  logic [7:0] rx = '0;
  frame_t     cur = '{8'h00, 1'b0, 1'b0, 1'b0};

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        ph = 0;
        done_expect = 1'b0;
        gap = 0;
        last_tx = Tx_o;
      end else if (!BaudSig_i) begin
        check("tx_stable", Tx_o, last_tx);
        check("done_low", ByteDone_o, 0);
        last_tx = Tx_o;
      end else begin
        check("byte_done", ByteDone_o, done_expect);
        done_expect = 1'b0;
        case (ph)
          0: begin
            if (Tx_o == 1'b0) begin
              check("exp_pending", exp_q.size() != 0, 1);
              if (exp_q.size() != 0) cur = exp_q.pop_front();
              check("st_start", State_o, STARTBIT);
              check("busy_start", Busy_o, 1);
              last_gap = gap;
              gap = 0;
              bit_idx = 0;
              ph = 1;
            end else begin
              check("st_idle", State_o, INTERVAL);
              check("busy_idle", Busy_o, 0);
              gap++;
            end
          end
          1: begin
            rx[bit_idx] = Tx_o;
            check("st_data", State_o, DATABITS);
            check("bitcnt", BitCounter_o, bit_idx);
            bit_idx++;
            if (bit_idx == DB) begin
              check("data", rx, cur.data);
              stops_left = cur.two_stop ? 2 : 1;
              ph = cur.par_en ? 2 : 3;
            end
          end
          2: begin
            check("parity", Tx_o, cur.par_bit);
            check("st_parity", State_o, PARITYBIT);
            check("bitcnt_par", BitCounter_o, 0);
            ph = 3;
          end
          default: begin
            check("stop", Tx_o, 1);
            check("st_stop", State_o, STOPBIT);
            check("bitcnt_stop", BitCounter_o, 0);
            stops_left--;
            if (stops_left == 0) begin
              ph = 0;
              done_expect = 1'b1;
              frames_done++;
            end
          end
        endcase
        last_tx = Tx_o;
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    Data_i = d;
    DataValid_i = 1'b1;
    while (!DataReady_o && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", DataReady_o, 1);
    if (DataReady_o)
      exp_q.push_back('{data: d, par_en: p_ParityEnable_i,
                        par_bit: (^d) ^ p_ParityOdd_i, two_stop: p_TwoStop_i});
    @(posedge clk);
    #1;
    DataValid_i = 1'b0;
    Data_i = 8'($urandom);
  endtask

  task automatic wait_state(input logic [4:0] s);
    int n = 0;
    while (State_o != s && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("wait_state", State_o, s);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || ph != 0 || State_o != INTERVAL) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 20000, 1);
    repeat (40) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state", State_o, INTERVAL);
    check("rst_tx", Tx_o, 1);
    check("rst_bitcnt", BitCounter_o, 0);
    check("rst_done", ByteDone_o, 0);
    check("rst_busy", Busy_o, 0);
    check("rst_ready", DataReady_o, 1);
    rst = 1'b0;

    // single byte, 8N1
    send(8'hA5);
    wait_idle();
    check("frames_t1", frames_done, 1);

    // 0x07 with even then odd parity
    p_ParityEnable_i = 1'b1;
    p_ParityOdd_i = 1'b0;
    send(8'h07);
    wait_idle();
    p_ParityOdd_i = 1'b1;
    send(8'h07);
    wait_idle();
    check("frames_t2", frames_done, 3);

    // back-to-back with two stop bits
    p_ParityEnable_i = 1'b0;
    p_ParityOdd_i = 1'b0;
    p_TwoStop_i = 1'b1;
    send(8'h55);
    check("ready_after_cap", DataReady_o, 0);
    wait_state(STARTBIT);
    check("ready_after_load", DataReady_o, 1);
    send(8'hAA);
    wait_idle();
    check("b2b_gap", last_gap, 0);
    check("frames_t3", frames_done, 5);

    // enable dropped mid-frame with a byte held
    p_TwoStop_i = 1'b0;
    send(8'h3C);
    wait_state(DATABITS);
    send(8'hC3);
    @(negedge clk);
    p_Enable_i = 1'b0;
    check("ready_dis", DataReady_o, 0);
    begin
      int n = 0;
      while (frames_done != 6 && n < 5000) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (64) @(negedge clk);
    check("frames_t4a", frames_done, 6);
    check("dis_state", State_o, INTERVAL);
    check("dis_tx", Tx_o, 1);
    check("dis_ready", DataReady_o, 0);
    check("dis_held", exp_q.size(), 1);
    p_Enable_i = 1'b1;
    #1;
    check("reen_ready", DataReady_o, 0);
    wait_idle();
    check("frames_t4b", frames_done, 7);

    // asynchronous reset during the parity bit, with a byte held
    p_ParityEnable_i = 1'b1;
    send(8'h96);
    wait_state(DATABITS);
    send(8'h11);
    wait_state(PARITYBIT);
    #2;
    rst = 1'b1;
    #1;
    check("arst_tx", Tx_o, 1);
    check("arst_state", State_o, INTERVAL);
    check("arst_bitcnt", BitCounter_o, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_ready", DataReady_o, 1);
    repeat (80) @(negedge clk);
    check("arst_discard", State_o, INTERVAL);
    check("frames_t5", frames_done, 7);

    // single-copy upset in INTERVAL is outvoted and scrubbed
    p_ParityEnable_i = 1'b0;
    repeat (8) @(negedge clk);
    force dut.st_b = DATABITS;
    #1;
    release dut.st_b;
    #1;
    check("seu_vote", State_o, INTERVAL);
    check("seu_tx", Tx_o, 1);
    @(posedge clk);
    #1;
    check("seu_scrub", dut.st_b, INTERVAL);
    check("seu_state", State_o, INTERVAL);

    // a frame still goes out normally afterwards
    send(8'h5A);
    wait_idle();
    check("frames_t6", frames_done, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
